// File: rtl/counter_pkg.sv
// Shared constants for the counter bank: saturation mode selectors and the
// read-index sizing helper.
package counter_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // Smallest index width that can address n channels, never below one bit.
    function automatic int idx_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/counter_bank_lane.sv
// One accumulating counter: adder, wrap/saturate select, sticky overflow and
// terminal-count compare.
module counter_bank_lane
    import counter_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               SAT   = CNT_WRAP,
    parameter logic [WIDTH-1:0] TERM  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] inc,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             tc
);

    logic [WIDTH:0] sum;
    logic           carry;

    assign sum   = {1'b0, count} + {1'b0, inc};
    assign carry = sum[WIDTH];

    // clr wins over en; overflow is flagged on the same edge as the wrapped or clamped count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (en) begin
            if (carry && (SAT == CNT_SAT)) begin
                count <= '1;
            end else begin
                count <= sum[WIDTH-1:0];
            end
            if (carry) begin
                ovf <= 1'b1;
            end
        end
    end

    assign tc = (count >= TERM);

endmodule

// File: rtl/counter_bank.sv
// Bank of NCH accumulating counters with a one-cycle indexed read port.
// Optional snapshot shadow registers are enabled by COUNTER_BANK_SNAPSHOT_EN.
module counter_bank
    import counter_pkg::*;
#(
    parameter int               NCH   = 4,
    parameter int               WIDTH = 8,
    parameter int               SAT   = CNT_WRAP,
    parameter logic [WIDTH-1:0] TERM  = {WIDTH{1'b1}},
    localparam int              IDXW  = idx_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [NCH-1:0]       en,
    input  logic [NCH*WIDTH-1:0] inc,
    output logic [NCH*WIDTH-1:0] count,
    output logic [NCH-1:0]       ovf,
    output logic [NCH-1:0]       tc,
    input  logic                 rd_req,
    input  logic [IDXW-1:0]      rd_idx,
    output logic                 rd_valid,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_ovf,
    input  logic                 snap,
    output logic                 snap_valid
);

    localparam int NSLOT = 1 << IDXW;

    logic [NCH*WIDTH-1:0] src_count;
    logic [NCH-1:0]       src_ovf;
    logic [WIDTH-1:0]     slot_count [NSLOT];
    logic                 slot_ovf   [NSLOT];

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        counter_bank_lane #(
            .WIDTH (WIDTH),
            .SAT   (SAT),
            .TERM  (TERM)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .en    (en[g]),
            .inc   (inc[g*WIDTH +: WIDTH]),
            .count (count[g*WIDTH +: WIDTH]),
            .ovf   (ovf[g]),
            .tc    (tc[g])
        );
    end

`ifdef COUNTER_BANK_SNAPSHOT_EN
    logic [NCH*WIDTH-1:0] shadow_count;
    logic [NCH-1:0]       shadow_ovf;
    logic                 shadow_valid;

    // snap captures pre-edge values even when clr arrives on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_count <= '0;
            shadow_ovf   <= '0;
            shadow_valid <= 1'b0;
        end else if (snap) begin
            shadow_count <= count;
            shadow_ovf   <= ovf;
            shadow_valid <= 1'b1;
        end else if (clr) begin
            shadow_count <= '0;
            shadow_ovf   <= '0;
            shadow_valid <= 1'b0;
        end
    end

    assign src_count  = shadow_count;
    assign src_ovf    = shadow_ovf;
    assign snap_valid = shadow_valid;
`else
    wire unused_snap = snap;

    assign src_count  = count;
    assign src_ovf    = ovf;
    assign snap_valid = 1'b0;
`endif

    // Pad the read table to a power of two so out-of-range indices read as zero.
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            slot_count[i] = '0;
            slot_ovf[i]   = 1'b0;
        end
        for (int i = 0; i < NCH; i++) begin
            slot_count[i] = src_count[i*WIDTH +: WIDTH];
            slot_ovf[i]   = src_ovf[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_ovf   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= slot_count[rd_idx];
                rd_ovf  <= slot_ovf[rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_counter_bank.sv
// Directed self-checking bench for counter_bank: a wrapping and a saturating
// instance share stimulus; expectations follow COUNTER_BANK_SNAPSHOT_EN.
module tb_counter_bank;
    import counter_pkg::*;

    // Five channels so that read index 5 is representable and out of range.
    localparam int NCH   = 5;
    localparam int WIDTH = 8;
    localparam int IDXW  = idx_width(NCH);
`ifdef COUNTER_BANK_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 clr;
    logic [NCH-1:0]       en;
    logic [NCH*WIDTH-1:0] inc;
    logic                 rd_req;
    logic [IDXW-1:0]      rd_idx;
    logic                 snap;

    logic [NCH*WIDTH-1:0] w_count, s_count;
    logic [NCH-1:0]       w_ovf, s_ovf, w_tc, s_tc;
    logic                 w_rd_valid, s_rd_valid, w_rd_ovf, s_rd_ovf;
    logic [WIDTH-1:0]     w_rd_data, s_rd_data;
    logic                 w_snap_valid, s_snap_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_bank #(.NCH(NCH), .WIDTH(WIDTH), .SAT(CNT_WRAP), .TERM(8'd200)) dut_w (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .inc(inc),
        .count(w_count), .ovf(w_ovf), .tc(w_tc),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(w_rd_valid),
        .rd_data(w_rd_data), .rd_ovf(w_rd_ovf),
        .snap(snap), .snap_valid(w_snap_valid)
    );

    counter_bank #(.NCH(NCH), .WIDTH(WIDTH), .SAT(CNT_SAT), .TERM(8'd200)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .inc(inc),
        .count(s_count), .ovf(s_ovf), .tc(s_tc),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(s_rd_valid),
        .rd_data(s_rd_data), .rd_ovf(s_rd_ovf),
        .snap(snap), .snap_valid(s_snap_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inc(input int ch, input int val);
        inc[ch*WIDTH +: WIDTH] = val[WIDTH-1:0];
    endtask

    function automatic logic [31:0] lane(input logic [NCH*WIDTH-1:0] v, input int ch);
        return 32'(v[ch*WIDTH +: WIDTH]);
    endfunction

    initial begin
        rst_n = 1'b0; clr = 1'b0; en = '0; inc = '0;
        rd_req = 1'b0; rd_idx = '0; snap = 1'b0;
        step(); step();
        rst_n = 1'b1;

        // Async reset mid-accumulate
        en = '1;
        for (int i = 0; i < NCH; i++) set_inc(i, 7);
        rd_req = 1'b1; rd_idx = 0;
        step();
        check("pre_reset_count", lane(w_count, 0), 7);
        check("pre_reset_rd_valid", 32'(w_rd_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_count", 32'(w_count == '0 && s_count == '0), 1);
        check("reset_ovf_tc", 32'({w_ovf, s_ovf, w_tc, s_tc}), 0);
        check("reset_rd", 32'({w_rd_valid, w_rd_data, w_rd_ovf}), 0);
        check("reset_snap_valid", 32'(w_snap_valid), 0);
        #2 rst_n = 1'b1;
        en = '0; inc = '0; rd_req = 1'b0;

        // Wrap on dut_w channel 0, saturate on dut_s channel 2
        en = 5'b00101; set_inc(0, 250); set_inc(2, 250);
        step();
        check("load_ch0", lane(w_count, 0), 250);
        check("load_tc", 32'(w_tc[0]), 1);
        set_inc(0, 10); set_inc(2, 10);
        step();
        check("wrap_count", lane(w_count, 0), 4);
        check("wrap_ovf", 32'(w_ovf[0]), 1);
        check("wrap_tc", 32'(w_tc[0]), 0);
        check("sat_count", lane(s_count, 2), 255);
        check("sat_ovf", 32'(s_ovf[2]), 1);
        check("sat_tc", 32'(s_tc[2]), 1);
        en = 5'b00111; set_inc(0, 1); set_inc(1, 0); set_inc(2, 1);
        step();
        check("wrap_next_count", lane(w_count, 0), 5);
        check("wrap_ovf_sticky", 32'(w_ovf[0]), 1);
        check("sat_hold", lane(s_count, 2), 255);
        check("sat_ovf_sticky", 32'(s_ovf[2]), 1);
        check("inc0_count", lane(w_count, 1), 0);
        check("inc0_ovf", 32'(w_ovf[1]), 0);

        // clr beats en; read on the same edge returns the pre-clear value
        en = 5'b00010; inc = '0; set_inc(1, 100);
        step();
        check("load_ch1", lane(w_count, 1), 100);
        clr = 1'b1; set_inc(1, 5); rd_req = 1'b1; rd_idx = 1;
        step();
        check("clr_count", 32'(w_count == '0), 1);
        check("clr_ovf", 32'(w_ovf), 0);
        check("clr_rd_valid", 32'(w_rd_valid), 1);
        check("clr_rd_data", 32'(w_rd_data), SNAP ? 0 : 100);
        clr = 1'b0; en = '0; rd_req = 1'b0;
        step();
        check("rd_valid_pulse", 32'(w_rd_valid), 0);

        // Streaming reads, channel 0 overflowed to 11
        en = '1; set_inc(0, 250); set_inc(1, 22); set_inc(2, 33); set_inc(3, 44); set_inc(4, 55);
        step();
        en = 5'b00001; set_inc(0, 17);
        step();
        check("stream_pre_ovf", 32'(w_ovf), 1);
        en = '0; rd_req = 1'b1;
        rd_idx = 0; step();
        check("stream0_data", 32'(w_rd_data), SNAP ? 0 : 11);
        check("stream0_ovf", 32'(w_rd_ovf), SNAP ? 0 : 1);
        rd_idx = 1; step();
        check("stream1_data", 32'(w_rd_data), SNAP ? 0 : 22);
        check("stream1_ovf", 32'(w_rd_ovf), 0);
        rd_idx = 2; step();
        check("stream2_data", 32'(w_rd_data), SNAP ? 0 : 33);
        rd_idx = 3; step();
        check("stream3_data", 32'(w_rd_data), SNAP ? 0 : 44);
        check("stream3_valid", 32'(w_rd_valid), 1);
        rd_idx = 5; step();
        check("stream5_valid", 32'(w_rd_valid), 1);
        check("stream5_data", 32'(w_rd_data), 0);
        check("stream5_ovf", 32'(w_rd_ovf), 0);
        rd_req = 1'b0; step();
        check("stream_end_valid", 32'(w_rd_valid), 0);

        // Snapshot, then three more increments
        clr = 1'b1; step();
        clr = 1'b0; en = 5'b01111;
        set_inc(0, 10); set_inc(1, 20); set_inc(2, 30); set_inc(3, 40);
        step();
        en = '0; snap = 1'b1; step();
        snap = 1'b0;
        check("snap_valid_set", 32'(w_snap_valid), SNAP ? 1 : 0);
        en = 5'b01111;
        for (int i = 0; i < 4; i++) set_inc(i, 1);
        step(); step(); step();
        en = '0; rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_idx = IDXW'(i);
            step();
            check($sformatf("snap_rd%0d", i), 32'(w_rd_data), SNAP ? 32'(10 * (i + 1)) : 32'(10 * (i + 1) + 3));
        end
        check("snap_valid_hold", 32'(w_snap_valid), SNAP ? 1 : 0);

        // snap+clr on one edge keeps pre-clear shadow; clr alone empties it
        rd_req = 1'b0; snap = 1'b1; clr = 1'b1; step();
        snap = 1'b0; clr = 1'b0;
        check("snapclr_count", lane(w_count, 0), 0);
        check("snapclr_valid", 32'(w_snap_valid), SNAP ? 1 : 0);
        rd_req = 1'b1; rd_idx = 0; step();
        check("snapclr_rd", 32'(w_rd_data), SNAP ? 13 : 0);
        rd_req = 1'b0; clr = 1'b1; step();
        clr = 1'b0;
        check("clr_snap_valid", 32'(w_snap_valid), 0);
        rd_req = 1'b1; rd_idx = 0; step();
        check("clr_snap_rd", 32'(w_rd_data), 0);
        rd_req = 1'b0; step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
